// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial sample link (transmit and receive sides).
package serial_link_pkg;

  localparam int SERIAL_DATA_WIDTH = 24;
  localparam int SERIAL_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and wrap-bit pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_nxt = wr_ptr + (AW+1)'(do_push);
    rd_nxt = rd_ptr + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial LSB-first transmitter feeding the FIR serial input link.
// Optional word counter output enabled by SERIAL_WORD_TX_COUNT_EN.
module serial_word_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = SERIAL_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = SERIAL_GAP_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic                  o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  output tx_state_t             o_state
`ifdef SERIAL_WORD_TX_COUNT_EN
  ,
  output logic [31:0]           o_words_sent
`endif
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_CYCLES - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bit_cnt;
  logic [GCW-1:0]        gap_cnt;
  logic                  dout_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  last_xfer;

  // Both handshakes are plain valid/ready: a transfer happens on a rising edge
  // where the sender's valid and the receiver's ready are both high.
  assign o_word_ready = i_en && !fifo_full;
  assign push         = i_word_valid && o_word_ready;
  assign pop          = i_en && !fifo_empty &&
                        ((state == IDLE) || ((state == GAP) && (gap_cnt == '0)));
  assign last_xfer    = (state == SHIFT) && i_ready && (bit_cnt == BIT_LAST);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (push),
    .din   (i_word),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= fifo_dout;
            dout_q  <= fifo_dout[0];
            valid_q <= 1'b1;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_ready) begin
            shreg <= shreg >> 1;
            if (last_xfer) begin
              dout_q  <= 1'b0;
              valid_q <= 1'b0;
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              dout_q  <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (pop) begin
              shreg   <= fifo_dout;
              dout_q  <= fifo_dout[0];
              valid_q <= 1'b1;
              bit_cnt <= '0;
              state   <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_dout       = dout_q;
  assign o_dout_valid = valid_q;
  assign o_state      = state;

`ifdef SERIAL_WORD_TX_COUNT_EN
  logic [31:0] words_sent;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) words_sent <= '0;
    else if (last_xfer) words_sent <= words_sent + 32'd1;
  end

  assign o_words_sent = words_sent;
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: latency, back-pressure, burst/full,
// enable drop, async reset mid-word and the optional word counter.
module tb_serial_word_tx;
  import serial_link_pkg::*;

  logic        tb_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [23:0] i_word;
  logic        i_word_valid;
  logic        o_word_ready;
  logic        o_dout;
  logic        o_dout_valid;
  logic        i_ready;
  tx_state_t   o_state;
`ifdef SERIAL_WORD_TX_COUNT_EN
  logic [31:0] o_words_sent;
`endif

  int n_vec = 0;
  int n_err = 0;
  int hold_bad = 0;

  serial_word_tx #(
    .DATA_WIDTH (24),
    .FIFO_DEPTH (4),
    .GAP_CYCLES (2)
  ) dut (
    .i_clk        (tb_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_word       (i_word),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_ready      (i_ready),
    .o_state      (o_state)
`ifdef SERIAL_WORD_TX_COUNT_EN
    ,
    .o_words_sent (o_words_sent)
`endif
  );

  // clock / reset
  always #5 tb_clk = ~tb_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [23:0] w);
    int t;
    t = 0;
    i_word       = w;
    i_word_valid = 1'b1;
    while (!o_word_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("push_timeout", 32'(o_word_ready), 32'd1);
    tick();
    i_word_valid = 1'b0;
  endtask

  // Collects one serial word; a bit is taken whenever i_ready is driven high.
  task automatic rx_word(input bit toggle, input int en_drop_bit,
                         output logic [23:0] w, output int hi, output int wc);
    int   k;
    bit   tgl;
    bit   hold_pending;
    logic prev;
    w = '0; hi = 0; wc = 0; k = 0; tgl = 1'b0; hold_pending = 1'b0; prev = 1'b0;
    while (!o_dout_valid && wc < 100) begin
      tick();
      wc++;
    end
    check("rx_start", 32'(o_dout_valid), 32'd1);
    while (o_dout_valid && hi < 200) begin
      if (hold_pending && o_dout !== prev) hold_bad++;
      i_ready = toggle ? tgl : 1'b1;
      tgl = !tgl;
      if (k == en_drop_bit) i_en = 1'b0;
      if (i_ready) begin
        if (k < 24) w[k] = o_dout;
        k++;
        hold_pending = 1'b0;
      end else begin
        prev = o_dout;
        hold_pending = 1'b1;
      end
      hi++;
      tick();
    end
    i_ready = 1'b1;
  endtask

  task automatic idle_watch(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      if (o_dout_valid) highs++;
      tick();
    end
  endtask

  // scoreboard for the burst test
  logic [23:0] exp_q[$];

  initial begin
    logic [23:0] w;
    int          hi;
    int          wc;
    int          highs;

    i_rst = 1'b0; i_en = 1'b0; i_word = '0; i_word_valid = 1'b0; i_ready = 1'b1;
    #1;
    check("rst_ready_en0", 32'(o_word_ready), 32'd0);
    i_en = 1'b1;
    #1;
    check("rst_ready_en1", 32'(o_word_ready), 32'd1);
    check("rst_valid", 32'(o_dout_valid), 32'd0);
    check("rst_dout", 32'(o_dout), 32'd0);
    check("rst_state", 32'(o_state), 32'(IDLE));
    tick(); tick();
    i_rst = 1'b1;
    tick();

    // single word, latency and framing
    push(24'hA53C0F);
    check("t1_no_bypass", 32'(o_dout_valid), 32'd0);
    tick();
    check("t1_latency_valid", 32'(o_dout_valid), 32'd1);
    check("t1_latency_bit0", 32'(o_dout), 32'd1);
    rx_word(1'b0, -1, w, hi, wc);
    check("t1_word", 32'(w), 32'hA53C0F);
    check("t1_valid_cycles", 32'(hi), 32'd24);
    check("t1_valid_low_after", 32'(o_dout_valid), 32'd0);
    idle_watch(4, highs);

    // back-pressure: i_ready alternates 0/1
    hold_bad = 0;
    push(24'h800001);
    rx_word(1'b1, -1, w, hi, wc);
    check("t2_word", 32'(w), 32'h800001);
    check("t2_valid_cycles", 32'(hi), 32'd48);
    check("t2_hold", 32'(hold_bad), 32'd0);
    idle_watch(4, highs);

    // burst: first word is popped after one edge, so five pushes fill the FIFO
    i_ready = 1'b0;
    exp_q = {24'h123456, 24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0, 24'h000001};
    foreach (exp_q[i]) push(exp_q[i]);
    check("t3_full_ready", 32'(o_word_ready), 32'd0);
    i_word = 24'hDEAD00; i_word_valid = 1'b1;
    tick();
    i_word_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_word(1'b0, -1, w, hi, wc);
      check("t3_word", 32'(w), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      check("t3_len", 32'(hi), 32'd24);
      if (i > 0) check("t3_gap", 32'(wc), 32'd2);
    end
    idle_watch(8, highs);
    check("t3_refused_push", 32'(highs), 32'd0);

    // enable drop during bit 10 of word 1 with word 2 buffered
    i_ready = 1'b0;
    push(24'h5A5A5A);
    push(24'h3C3C3C);
    rx_word(1'b0, 10, w, hi, wc);
    check("t4_word1", 32'(w), 32'h5A5A5A);
    check("t4_len1", 32'(hi), 32'd24);
    check("t4_ready_en0", 32'(o_word_ready), 32'd0);
    idle_watch(10, highs);
    check("t4_held_off", 32'(highs), 32'd0);
    i_en = 1'b1;
    rx_word(1'b0, -1, w, hi, wc);
    check("t4_word2", 32'(w), 32'h3C3C3C);
    check("t4_len2", 32'(hi), 32'd24);
    idle_watch(4, highs);

    // async reset in the middle of a word
    i_ready = 1'b0;
    push(24'hFFFFFF);
    push(24'hABCDEF);
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("t5_pre_valid", 32'(o_dout_valid), 32'd1);
    check("t5_pre_dout", 32'(o_dout), 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    check("t5_async_valid", 32'(o_dout_valid), 32'd0);
    check("t5_async_dout", 32'(o_dout), 32'd0);
    check("t5_async_state", 32'(o_state), 32'(IDLE));
    #2;
    i_rst = 1'b1;
    tick();
    check("t5_ready_after", 32'(o_word_ready), 32'd1);
    push(24'h000123);
    rx_word(1'b0, -1, w, hi, wc);
    check("t5_word", 32'(w), 32'h000123);
    idle_watch(10, highs);
    check("t5_buffer_lost", 32'(highs), 32'd0);

`ifdef SERIAL_WORD_TX_COUNT_EN
    check("t6_count_after_rst", o_words_sent, 32'd1);
    i_ready = 1'b0;
    push(24'h000111);
    push(24'h000222);
    push(24'h000333);
    for (int i = 0; i < 3; i++) begin
      rx_word(1'b0, -1, w, hi, wc);
      check("t6_count_step", o_words_sent, 32'(2 + i));
    end
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
